// File: rtl/stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the hazard controller.
// master : the pipeline side. It drives ready, the per-stage stall requests
//          and the EX redirect pulse, and it consumes the stall vector,
//          flush, the debug state and the stall-cycle counter.
// slave  : stall_ctrl itself.
interface stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             rdy;
  logic             stallreq_if;
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             stallreq_mem;
  logic             goback_from_ex;
  logic [5:0]       stall;
  logic             flush;
  logic [1:0]       busy_state;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rdy, stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, goback_from_ex,
    input  stall, flush, busy_state, stall_cycles
  );

  modport slave (
    input  rdy, stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, goback_from_ex,
    output stall, flush, busy_state, stall_cycles
  );
endinterface

// File: rtl/stall_ctrl.sv
// Central pipeline hazard controller for the 5-stage core.
// It merges the IF/ID/EX/MEM stall requests into the shared stall vector.
// It sequences EX mispredict redirects, deferring them while EX/MEM is held.
// After a redirect it ignores stale IF stall requests for a fixed window.
// It also counts stalled cycles with a saturating counter.
// Ports:
//   clk  : core clock
//   rst  : asynchronous reset, active-low
//   bus  : stall_ctrl_if.slave
//          inputs  : rdy, stallreq_*, goback_from_ex
//          outputs : stall[5:0] (pc, if_id, id_ex, ex_mem, mem_wb, wb), flush,
//                    busy_state, stall_cycles
module stall_ctrl #(
  parameter int CNT_W           = 32,
  parameter int REDIRECT_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    SUPPRESS = 2'd2
  } state_t;

  localparam logic [3:0]       RELOAD  = 4'(REDIRECT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  logic [3:0]       sup_cnt_q, sup_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [5:0]       stall_c;
  logic             flush_c;

  // Stall vector: a freeze stops everything. Otherwise the deepest requesting
  // stage wins. IF requests are stale right after a redirect, so they are
  // masked while in SUPPRESS.
  always_comb begin
    stall_c = 6'b000000;
    if (!bus.rdy)                                         stall_c = 6'b111111;
    else if (bus.stallreq_mem)                            stall_c = 6'b011111;
    else if (bus.stallreq_ex)                             stall_c = 6'b001111;
    else if (bus.stallreq_id)                             stall_c = 6'b000111;
    else if (bus.stallreq_if && (state_q != SUPPRESS))    stall_c = 6'b000011;
  end

  // Redirect sequencing. A redirect can only be applied when ex_mem is moving
  // (stall[3]=0); otherwise it is parked in HOLD until the hold clears.
  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    sup_cnt_d      = sup_cnt_q;
    stall_cycles_d = stall_cycles_q;
    flush_c        = 1'b0;

    if (bus.rdy) begin
      if ((stall_c != 6'b000000) && (stall_cycles_q != CNT_MAX))
        stall_cycles_d = stall_cycles_q + CNT_ONE;

      case (state_q)
        HOLD: begin
          // EX is frozen while here, so a further goback is a repeat and is ignored.
          if (pending_q && !stall_c[3]) begin
            flush_c   = 1'b1;
            pending_d = 1'b0;
            state_d   = SUPPRESS;
            sup_cnt_d = RELOAD;
          end else if (!pending_q) begin
            state_d   = IDLE;
          end
        end
        IDLE, SUPPRESS: begin
          // The count holds the remaining masked cycles, this one included.
          if (state_q == SUPPRESS) begin
            if (sup_cnt_q <= 4'd1) begin
              state_d   = IDLE;
              sup_cnt_d = 4'd0;
            end else begin
              sup_cnt_d = sup_cnt_q - 4'd1;
            end
          end
          if (bus.goback_from_ex) begin
            if (!stall_c[3]) begin
              flush_c   = 1'b1;
              state_d   = SUPPRESS;
              sup_cnt_d = RELOAD;
            end else begin
              pending_d = 1'b1;
              state_d   = HOLD;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          pending_d = 1'b0;
          sup_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      pending_q      <= 1'b0;
      sup_cnt_q      <= 4'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      sup_cnt_q      <= sup_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stall        = stall_c;
  assign bus.flush        = flush_c;
  assign bus.busy_state   = state_q;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_stall_ctrl.sv
module tb_stall_ctrl;
  localparam int CNT_W = 4;
  localparam int RC    = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stall_ctrl_if #(.CNT_W(CNT_W)) bus ();
  stall_ctrl #(.CNT_W(CNT_W), .REDIRECT_CYCLES(RC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [5:0] stall;
    logic       flush;
    logic [1:0] st;
    logic [3:0] sc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   m_state, m_cnt, m_sc;
  logic [5:0] o_stall;
  logic       o_flush;
  logic [3:0] sc_saved;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_sc    = 0;
    sb.delete();
  endtask

  // Drive one cycle of stimulus at the negedge. Push the model's expectation,
  // compare the combinational outputs mid-cycle, then advance the model on the
  // clock edge.
  task automatic step(input logic r, input logic i_if, input logic i_id,
                      input logic i_ex, input logic i_mem, input logic gb);
    exp_t       e;
    exp_t       got;
    logic [5:0] s;
    int         nxt;
    bus.rdy = r; bus.stallreq_if = i_if; bus.stallreq_id = i_id;
    bus.stallreq_ex = i_ex; bus.stallreq_mem = i_mem; bus.goback_from_ex = gb;
    if (!r)                          s = 6'h3f;
    else if (i_mem)                  s = 6'h1f;
    else if (i_ex)                   s = 6'h0f;
    else if (i_id)                   s = 6'h07;
    else if (i_if && m_state != 2)   s = 6'h03;
    else                             s = 6'h00;
    e.stall = s;
    e.flush = r && !s[3] && ((m_state == 1) || gb);
    e.st    = 2'(m_state);
    e.sc    = 4'(m_sc);
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    o_stall = bus.stall;
    o_flush = bus.flush;
    chk("stall", {2'b0, bus.stall}, {2'b0, got.stall});
    chk("flush", {7'b0, bus.flush}, {7'b0, got.flush});
    chk("state", {6'b0, bus.busy_state}, {6'b0, got.st});
    chk("count", {4'b0, bus.stall_cycles}, {4'b0, got.sc});
    @(posedge clk);
    if (r) begin
      if (s != 6'h00 && m_sc < 15) m_sc++;
      if (m_state == 1) begin
        if (!s[3]) begin m_state = 2; m_cnt = RC; end
      end else begin
        nxt = m_state;
        if (m_state == 2) begin
          if (m_cnt <= 1) begin nxt = 0; m_cnt = 0; end
          else m_cnt--;
        end
        if (gb) begin
          if (!s[3]) begin nxt = 2; m_cnt = RC; end
          else nxt = 1;
        end
        m_state = nxt;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    bus.rdy = 1'b1; bus.stallreq_if = 1'b0; bus.stallreq_id = 1'b0;
    bus.stallreq_ex = 1'b0; bus.stallreq_mem = 1'b0; bus.goback_from_ex = 1'b0;
    model_reset();
    #1;
    chk("rst_stall", {2'b0, bus.stall}, 8'h00);
    chk("rst_flush", {7'b0, bus.flush}, 8'h00);
    chk("rst_state", {6'b0, bus.busy_state}, 8'h00);
    chk("rst_count", {4'b0, bus.stall_cycles}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Idle after reset release
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0);

    // ID load-use hazard outranks IF
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 0, 0);
      chk("id_stall", {2'b0, o_stall}, 8'h07);
    end
    chk("id_count", {4'b0, bus.stall_cycles}, 8'h03);

    // Redirect in IDLE: flush now, one masked IF cycle, then IF honoured
    step(1, 0, 0, 0, 0, 1);
    chk("gb_flush", {7'b0, o_flush}, 8'h01);
    step(1, 1, 0, 0, 0, 0);
    chk("sup_stall", {2'b0, o_stall}, 8'h00);
    step(1, 1, 0, 0, 0, 0);
    chk("if_stall", {2'b0, o_stall}, 8'h03);

    // Redirect under a MEM stall, with a freeze in the middle of HOLD
    step(1, 0, 0, 0, 1, 1);
    chk("hold_stall", {2'b0, o_stall}, 8'h1f);
    chk("hold_noflush", {7'b0, o_flush}, 8'h00);
    step(1, 0, 0, 0, 1, 0);
    chk("hold_state", {6'b0, bus.busy_state}, 8'h01);
    sc_saved = bus.stall_cycles;
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 1, 1);
      chk("frz_stall", {2'b0, o_stall}, 8'h3f);
      chk("frz_noflush", {7'b0, o_flush}, 8'h00);
    end
    chk("frz_count", {4'b0, bus.stall_cycles}, {4'b0, sc_saved});
    chk("frz_state", {6'b0, bus.busy_state}, 8'h01);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("hold_flush", {7'b0, o_flush}, 8'h01);
    chk("to_sup", {6'b0, bus.busy_state}, 8'h02);
    step(1, 0, 0, 0, 0, 0);
    chk("to_idle", {6'b0, bus.busy_state}, 8'h00);

    // EX stall and a redirect with ID stall (flush wins, stall[2] stays)
    step(1, 0, 0, 1, 0, 0);
    chk("ex_stall", {2'b0, o_stall}, 8'h0f);
    step(1, 0, 1, 0, 0, 1);
    chk("gbid_stall", {2'b0, o_stall}, 8'h07);
    chk("gbid_flush", {7'b0, o_flush}, 8'h01);
    step(1, 0, 0, 0, 0, 0);

    // Saturation of the stall-cycle counter
    for (int i = 0; i < 20; i++) step(1, 0, 1, 0, 0, 0);
    chk("sat_count", {4'b0, bus.stall_cycles}, 8'h0f);
    step(1, 0, 1, 0, 0, 0);

    // Asynchronous reset in the middle of SUPPRESS
    step(1, 0, 0, 0, 0, 1);
    chk("pre_rst_state", {6'b0, bus.busy_state}, 8'h02);
    bus.goback_from_ex = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_state", {6'b0, bus.busy_state}, 8'h00);
    chk("arst_count", {4'b0, bus.stall_cycles}, 8'h00);
    chk("arst_stall", {2'b0, bus.stall}, 8'h00);
    chk("arst_flush", {7'b0, bus.flush}, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1, 1, 0, 0, 0, 0);
    chk("post_rst_if", {2'b0, o_stall}, 8'h03);
    step(1, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Central pipeline hazard controller for the 5-stage core.
- Collects stall requests from the IF, ID, EX and MEM stages and drives the shared stall vector consumed by pc_reg and every inter-stage register (if_id, id_ex, ex_mem, mem_wb).
- Sequences branch-mispredict redirects signalled by EX (goback), including redirects that arrive while a downstream stall is active.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- CNT_W, 32, width of the stall-cycle counter.
- REDIRECT_CYCLES, 1, cycles after an applied redirect during which stallreq_if is ignored (stale fetch); range 1..15.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-low.
- rdy  in  1  global ready; 0 freezes the whole pipeline.
- stallreq_if  in  1  IF waiting on the memory controller.
- stallreq_id  in  1  ID load-use hazard.
- stallreq_ex  in  1  EX multi-cycle operation.
- stallreq_mem  in  1  MEM load/store in flight.
- goback_from_ex  in  1  EX branch/jump mispredict, 1-cycle pulse.
- stall  out  6  stall vector: bit0 pc, 1 if_id, 2 id_ex, 3 ex_mem, 4 mem_wb, 5 wb; 1 = Stop.
- flush  out  1  redirect applied this cycle; if_id and id_ex load NOP.
- busy_state  out  2  FSM state, for debug.
- stall_cycles  out  CNT_W  count of cycles with stall != 0.

Behaviour:
- Reset (rst=0, async): stall=6'b000000, flush=0, state=IDLE, stall_cycles=0, pending redirect cleared, suppress counter cleared.
- All state updates on posedge clk. stall and flush are combinational from the current state and inputs, with zero latency.
- Freeze: rdy=0 forces stall=6'b111111 and flush=0. No state, counter or pending flag changes.
- Stall vector priority (highest wins), applied when rdy=1:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if (not suppressed) → 6'b000011
  - none → 6'b000000
- States:
  - IDLE: goback_from_ex=1 with stall[3]=0 → flush=1 this cycle, next state SUPPRESS, suppress counter loaded with REDIRECT_CYCLES. goback_from_ex=1 with stall[3]=1 → latch pending, next state HOLD.
  - HOLD: the stall vector is computed normally. On the first cycle with stall[3]=0: flush=1, pending cleared, next state SUPPRESS.
  - SUPPRESS: stallreq_if is masked from the stall equation. The counter decrements each cycle with rdy=1. At 0 → IDLE. A new goback in SUPPRESS is handled exactly as in IDLE, and the counter reloads.
  - State encoding: IDLE=0, HOLD=1, SUPPRESS=2.
- Simultaneous events:
  - goback together with stallreq_id: the redirect wins and flush=1. stall[2] is still asserted if stallreq_id=1, but ID content is discarded by flush.
  - goback together with stallreq_mem: the redirect goes to HOLD.
  - A second goback while in HOLD is ignored. The pending redirect is unique because EX is frozen.
- stall_cycles increments on each clock where rdy=1 and stall != 0. It saturates at all-ones and never wraps.
- Reset mid-HOLD or mid-SUPPRESS: the pending redirect is discarded and the block returns to IDLE immediately.

Test Plan:
- Reset release, no requests → stall=000000, flush=0, stall_cycles=0 for 10 cycles.
- stallreq_id=1 and stallreq_if=1 for 3 cycles → stall=000111 for exactly those cycles; stall_cycles=3.
- goback pulse in IDLE → flush=1 same cycle. The next cycle with stallreq_if=1 gives stall=000000 (suppressed), and stallreq_if is honoured again at cycle +2 (REDIRECT_CYCLES=1).
- stallreq_mem high for 4 cycles, goback pulse in cycle 1 → stall=011111 for those 4 cycles, busy_state=HOLD, flush=1 in cycle 5, then SUPPRESS, then IDLE.
- rdy=0 for 2 cycles during HOLD → stall=111111, state and counter unchanged. After rdy=1 the sequence resumes identically.
- Preload stall_cycles near saturation (CNT_W=4, 20 stalled cycles) → counter holds at 4'hF. Assert rst=0 asynchronously mid-SUPPRESS → all outputs zero before the next clock edge.
